irrigation_controller_multizone: RTL

// Next-generation automated irrigation controller. Replaces the combinational single-zone rules with synchronised,

---
 rtl/irrigation_controller_multizone.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/irrigation_controller_multizone.sv
// Multizone irrigation controller: synchronised/debounced sensors, hysteretic tank inlet,
// round-robin zone scheduler with bounded watering and guard gap, multiplexed 7-segment display.
module irrigation_controller_multizone #(
  parameter int ZONES           = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int MIN_ON_CYCLES   = 5000,
  parameter int MAX_ON_CYCLES   = 50000,
  parameter int GUARD_CYCLES    = 1000,
  parameter int SCAN_DIV        = 50000
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             high_level_indicator_i,
  input  logic             middle_level_indicator_i,
  input  logic             low_level_indicator_i,
  input  logic [ZONES-1:0] soil_dry_i,
  input  logic             air_humidity_i,
  input  logic             temperature_i,
  input  logic             selector_i,
  output logic             error_indicator_o,
  output logic             alarm_state_o,
  output logic             inlet_valve_o,
  output logic [ZONES-1:0] sprinkler_o,
  output logic [ZONES-1:0] drip_o,
  output logic [6:0]       segments_o,
  output logic [3:0]       digits_o
);

  localparam int ZW  = (ZONES > 1) ? $clog2(ZONES) : 1;
  localparam int NIN = ZONES + 6;
  localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW  = $clog2(MAX_ON_CYCLES + GUARD_CYCLES + 1);
  localparam int SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WATER = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_S     = 7'h12;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  logic [NIN-1:0] raw, sync1, sync2, deb;
  logic [DW-1:0]  db_cnt [NIN];

  // Bit packing of the sensor vector; soil bits sit at the bottom.
  assign raw = {selector_i, temperature_i, air_humidity_i, high_level_indicator_i,
                middle_level_indicator_i, low_level_indicator_i, soil_dry_i};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      // NOTE: the per-input counter array is plain flop storage, so it is cleared with
      // everything else; a RAM-backed array would be left unreset instead.
      for (int i = 0; i < NIN; i++) db_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep the two synchroniser stages as two real flops.
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < NIN; i++) begin
        if (sync2[i] != deb[i]) begin
          if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            deb[i]    <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  logic [ZONES-1:0] soil;
  logic l_lvl, m_lvl, h_lvl, humid, temp, sel;
  logic err_c, alarm_c, mode_c;

  assign soil    = deb[ZONES-1:0];
  assign l_lvl   = deb[ZONES];
  assign m_lvl   = deb[ZONES+1];
  assign h_lvl   = deb[ZONES+2];
  assign humid   = deb[ZONES+3];
  assign temp    = deb[ZONES+4];
  assign sel     = deb[ZONES+5];
  assign err_c   = (h_lvl & ~m_lvl) | (m_lvl & ~l_lvl);
  assign alarm_c = ~l_lvl | err_c;
  assign mode_c  = m_lvl & (temp | ~humid);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      error_indicator_o <= 1'b0;
      alarm_state_o     <= 1'b0;
      inlet_valve_o     <= 1'b0;
    end else begin
      error_indicator_o <= err_c;
      alarm_state_o     <= alarm_c;
      if (!inlet_valve_o && !m_lvl && !err_c) inlet_valve_o <= 1'b1;
      else if (inlet_valve_o && (h_lvl || err_c)) inlet_valve_o <= 1'b0;
    end
  end

  logic [1:0]       state_q;
  logic [ZW-1:0]    zone_q, ptr_q, grant;
  logic             mode_q, found;
  logic [CW-1:0]    cnt_q;
  logic [ZONES-1:0] grant_mask;
  int               idx;

  // Search for the first requesting zone starting at the round-robin pointer.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned,
    // which would otherwise infer a latch.
    found = 1'b0;
    grant = ptr_q;
    idx   = 0;
    for (int k = 0; k < ZONES; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= ZONES) idx = idx - ZONES;
      if (!found && soil[idx]) begin
        found = 1'b1;
        grant = ZW'(idx);
      end
    end
  end

  assign grant_mask = ZONES'(1) << grant;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      zone_q      <= '0;
      ptr_q       <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      sprinkler_o <= '0;
      drip_o      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!alarm_c && found) begin
            state_q <= ST_WATER;
            zone_q  <= grant;
            ptr_q   <= (grant == ZW'(ZONES - 1)) ? '0 : grant + ZW'(1);
            mode_q  <= mode_c;
            cnt_q   <= '0;
            if (mode_c) sprinkler_o <= grant_mask;
            else        drip_o      <= grant_mask;
          end
        end
        ST_WATER: begin
          if (alarm_c || (!soil[zone_q] && cnt_q >= CW'(MIN_ON_CYCLES)) ||
              cnt_q == CW'(MAX_ON_CYCLES - 1)) begin
            state_q     <= ST_GUARD;
            cnt_q       <= '0;
            sprinkler_o <= '0;
            drip_o      <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_GUARD: begin
          if (cnt_q == CW'(GUARD_CYCLES - 1)) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          sprinkler_o <= '0;
          drip_o      <= '0;
        end
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  logic [SW-1:0] scan_cnt;
  logic [1:0]    slot_q;
  logic          page_q;
  logic [6:0]    seg_c;

  always_comb begin
    seg_c = SEG_BLANK;
    if (!page_q) begin
      if (slot_q == 2'd3) begin
        if (err_c)      seg_c = SEG_E;
        else if (h_lvl) seg_c = seg7(4'd3);
        else if (m_lvl) seg_c = seg7(4'd2);
        else if (l_lvl) seg_c = seg7(4'd1);
        else            seg_c = seg7(4'd0);
      end
    end else if (slot_q == 2'd3) begin
      seg_c = (state_q == ST_WATER) ? seg7(4'(zone_q) + 4'd1) : seg7(4'd0);
    end else if (slot_q == 2'd2) begin
      if (state_q == ST_WATER) seg_c = mode_q ? SEG_S : SEG_D;
      else                     seg_c = SEG_DASH;
    end
  end

  // Slots run 3,2,1,0 so the leftmost digit is refreshed first; the page switches only at a slot edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      scan_cnt   <= '0;
      slot_q     <= '0;
      page_q     <= 1'b0;
      digits_o   <= 4'hF;
      segments_o <= SEG_BLANK;
    end else begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        slot_q   <= slot_q - 2'd1;
        page_q   <= sel;
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
      digits_o   <= ~(4'b0001 << slot_q);
      segments_o <= seg_c;
    end
  end

endmodule
